// File: rtl/demod_channel_responder_pkg.sv
// Shared types and helpers for the single-channel phase-sensitive demodulator.
// Contents: FSM state encoding, packed-result field positions, sat16 clamp.
package demod_channel_responder_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAcq    = 2'd1,
        StFinish = 2'd2,
        StHold   = 2'd3
    } demodState_t;

    // Field positions inside the packed 32-bit I/Q result.
    localparam int unsigned I_MSB = 31;
    localparam int unsigned I_LSB = 16;
    localparam int unsigned Q_MSB = 15;
    localparam int unsigned Q_LSB = 0;

    // Input width of sat16; wide enough for any accumulator after shifting.
    localparam int unsigned SatInW = 64;

    // Clamp a signed value to the signed 16-bit range 0x8000..0x7FFF.
    function automatic logic [15:0] sat16(input logic signed [SatInW-1:0] x);
        logic [15:0] r;
        if (x > 64'sd32767) begin
            r = 16'h7FFF;
        end else if (x < -64'sd32768) begin
            r = 16'h8000;
        end else begin
            r = x[15:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/demod_ref_gen.sv
// Square-wave reference generator for the demodulator.
// Ports: Clk, Rst (async active-low), Clear (phase back to 0),
//        Advance (step phase modulo 2*HalfPeriod), NegI/NegQ (1 = reference sign is -1).
// Signs are registered from the next phase so they always match the current phase.
module demod_ref_gen
    import demod_channel_responder_pkg::*;
#(
    parameter int unsigned HalfPeriod = 8
) (
    input  logic Clk,
    input  logic Rst,
    input  logic Clear,
    input  logic Advance,
    output logic NegI,
    output logic NegQ
);

    localparam int unsigned PhaseW = $clog2(2 * HalfPeriod);
    localparam logic [PhaseW-1:0] PhaseLast = PhaseW'(2 * HalfPeriod - 1);
    localparam logic [PhaseW-1:0] IEdge     = PhaseW'(HalfPeriod);
    localparam logic [PhaseW-1:0] QLo       = PhaseW'(HalfPeriod / 2);
    localparam logic [PhaseW-1:0] QHi       = PhaseW'(3 * HalfPeriod / 2);

    logic [PhaseW-1:0] phase;
    logic [PhaseW-1:0] phaseNext;

    // Next phase: clear has priority over advance.
    always_comb begin
        phaseNext = phase;
        if (Clear) begin
            phaseNext = '0;
        end else if (Advance) begin
            phaseNext = (phase == PhaseLast) ? '0 : phase + PhaseW'(1);
        end
    end

    // Phase and sign registers; at phase 0 I is +1 and Q is -1.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            phase <= '0;
            NegI  <= 1'b0;
            NegQ  <= 1'b1;
        end else begin
            phase <= phaseNext;
            NegI  <= (phaseNext >= IEdge);
            NegQ  <= !((phaseNext >= QLo) && (phaseNext < QHi));
        end
    end

endmodule

// File: rtl/demod_channel_responder.sv
// Single-channel phase-sensitive demodulator, responder side of DemodEn/DemodReady.
// Ports: Clk, Rst (async active-low), DemodEn (request level), AdcData/AdcValid (signed
//        samples), DemodReady (result valid, held until DemodEn drops),
//        DemodResult ({sat I, sat Q}), Busy (acquiring or finishing).
module demod_channel_responder
    import demod_channel_responder_pkg::*;
#(
    parameter int unsigned AdcWidth   = 14,
    parameter int unsigned NumSamples = 1024,
    parameter int unsigned HalfPeriod = 8,
    parameter int unsigned ShiftR     = 8
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic                       DemodEn,
    input  logic signed [AdcWidth-1:0] AdcData,
    input  logic                       AdcValid,
    output logic                       DemodReady,
    output logic [31:0]                DemodResult,
    output logic                       Busy
);

    localparam int unsigned AccW   = AdcWidth + 16;
    localparam int unsigned CountW = 16;
    localparam logic [CountW-1:0] CountLast = CountW'(NumSamples - 1);

    demodState_t state, stateNext;

    logic signed [AccW-1:0] accI, accQ, accINext, accQNext;
    logic signed [AccW-1:0] sampleExt;
    logic [CountW-1:0]      count, countNext;
    logic                   readyNext, busyNext;
    logic [31:0]            resultNext;
    logic                   refClear, refAdvance, negI, negQ;

    // Sign-extend first so negating the most-negative sample cannot wrap.
    assign sampleExt = AccW'(AdcData);

    demod_ref_gen #(
        .HalfPeriod(HalfPeriod)
    ) uRefGen (
        .Clk    (Clk),
        .Rst    (Rst),
        .Clear  (refClear),
        .Advance(refAdvance),
        .NegI   (negI),
        .NegQ   (negQ)
    );

    // State register.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= StIdle;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state, datapath and output decode.
    always_comb begin
        stateNext  = state;
        accINext   = accI;
        accQNext   = accQ;
        countNext  = count;
        readyNext  = DemodReady;
        resultNext = DemodResult;
        refClear   = 1'b0;
        refAdvance = 1'b0;
        case (state)
            StIdle: begin
                if (DemodEn) begin
                    stateNext = StAcq;
                    accINext  = '0;
                    accQNext  = '0;
                    countNext = '0;
                    refClear  = 1'b1;
                end
            end
            StAcq: begin
                if (!DemodEn) begin
                    stateNext = StIdle;
                end else if (AdcValid) begin
                    accINext   = negI ? accI - sampleExt : accI + sampleExt;
                    accQNext   = negQ ? accQ - sampleExt : accQ + sampleExt;
                    countNext  = count + CountW'(1);
                    refAdvance = 1'b1;
                    if (count == CountLast) begin
                        stateNext = StFinish;
                    end
                end
            end
            StFinish: begin
                if (!DemodEn) begin
                    stateNext = StIdle;
                end else begin
                    stateNext                = StHold;
                    readyNext                = 1'b1;
                    resultNext[I_MSB:I_LSB]  = sat16(SatInW'(accI >>> ShiftR));
                    resultNext[Q_MSB:Q_LSB]  = sat16(SatInW'(accQ >>> ShiftR));
                end
            end
            StHold: begin
                if (!DemodEn) begin
                    stateNext = StIdle;
                    readyNext = 1'b0;
                end
            end
            default: begin
                stateNext = StIdle;
                readyNext = 1'b0;
            end
        endcase
        busyNext = (stateNext == StAcq) || (stateNext == StFinish);
    end

    // Datapath and registered outputs.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            accI        <= '0;
            accQ        <= '0;
            count       <= '0;
            DemodReady  <= 1'b0;
            DemodResult <= '0;
            Busy        <= 1'b0;
        end else begin
            accI        <= accINext;
            accQ        <= accQNext;
            count       <= countNext;
            DemodReady  <= readyNext;
            DemodResult <= resultNext;
            Busy        <= busyNext;
        end
    end

endmodule

// File: tb/tb_demod_channel_responder.sv
// Randomized self-checking bench for demod_channel_responder.
// The reference model accumulates each accepted sample against square-wave signs derived
// from the sample index, then clamps the sums; handshake timing is checked cycle by cycle.
module tb_demod_channel_responder;

    localparam int unsigned TbAdcW   = 14;
    localparam int unsigned TbNum    = 16;
    localparam int unsigned TbHalf   = 4;
    localparam int unsigned TbShift  = 0;
    localparam int          MaxCycle = 2000;

    logic                     Clk;
    logic                     Rst;
    logic                     DemodEn;
    logic signed [TbAdcW-1:0] AdcData;
    logic                     AdcValid;
    logic                     DemodReady;
    logic [31:0]              DemodResult;
    logic                     Busy;

    int compared   = 0;
    int mismatched = 0;

    demod_channel_responder #(
        .AdcWidth  (TbAdcW),
        .NumSamples(TbNum),
        .HalfPeriod(TbHalf),
        .ShiftR    (TbShift)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .DemodEn    (DemodEn),
        .AdcData    (AdcData),
        .AdcValid   (AdcValid),
        .DemodReady (DemodReady),
        .DemodResult(DemodResult),
        .Busy       (Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] clip16(input longint x);
        longint c;
        c = x;
        if (c > 32767) c = 32767;
        if (c < -32768) c = -32768;
        return 16'(c);
    endfunction

    // Sample for the given pattern at accepted-sample index idx.
    function automatic int genSample(input int mode, input int idx);
        int p;
        p = idx % (2 * TbHalf);
        case (mode)
            0:       return 100;
            1:       return (p < TbHalf) ? 100 : -100;
            2:       return (p < TbHalf) ? 8191 : -8191;
            3:       return (p < TbHalf) ? -8192 : 8191;
            default: return int'($urandom_range(16383)) - 8192;
        endcase
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // One request: validMode 0 = always valid, 1 = alternating, 2 = random.
    // dropAtFinish removes the request in the cycle after the last sample.
    task automatic doAcq(input int mode, input int validMode, input bit dropAtFinish,
                         input int holdCycles, output logic [31:0] seen);
        int got;
        int cyc;
        int d;
        int p;
        bit v;
        longint accI;
        longint accQ;
        logic [31:0] exp;
        got  = 0;
        cyc  = 0;
        accI = 0;
        accQ = 0;
        seen = '0;
        // Entry cycle: this sample must be ignored.
        DemodEn  = 1'b1;
        AdcValid = 1'b1;
        AdcData  = TbAdcW'($urandom);
        tick();
        checkVal("busyAcq", 32'(Busy), 32'd1);
        while (got < TbNum && cyc < MaxCycle) begin
            case (validMode)
                0:       v = 1'b1;
                1:       v = (cyc % 2) == 0;
                default: v = ($urandom_range(99) < 60);
            endcase
            d = v ? genSample(mode, got) : int'($urandom_range(16383)) - 8192;
            AdcValid = v;
            AdcData  = TbAdcW'(d);
            tick();
            cyc++;
            if (v) begin
                p = got % (2 * TbHalf);
                accI += (p < TbHalf) ? d : -d;
                accQ += (p >= TbHalf / 2 && p < 3 * TbHalf / 2) ? d : -d;
                got++;
            end
            if (got < TbNum && DemodReady) checkVal("readyEarly", 32'(DemodReady), 32'd0);
        end
        if (got < TbNum) checkVal("acqTimeout", 32'(got), 32'(TbNum));
        AdcValid = 1'b0;
        checkVal("readyBeforeLatency", 32'(DemodReady), 32'd0);
        if (dropAtFinish) begin
            DemodEn = 1'b0;
            tick();
            checkVal("readyAbortFinish", 32'(DemodReady), 32'd0);
            checkVal("busyAbortFinish", 32'(Busy), 32'd0);
            return;
        end
        tick();
        exp = {clip16(accI >>> TbShift), clip16(accQ >>> TbShift)};
        seen = DemodResult;
        checkVal("ready", 32'(DemodReady), 32'd1);
        checkVal("result", DemodResult, exp);
        checkVal("busyHold", 32'(Busy), 32'd0);
        for (int h = 0; h < holdCycles; h++) begin
            tick();
            checkVal("readyHeld", 32'(DemodReady), 32'd1);
            checkVal("resultHeld", DemodResult, exp);
        end
        DemodEn = 1'b0;
        tick();
        checkVal("readyDrop", 32'(DemodReady), 32'd0);
        checkVal("resultKept", DemodResult, exp);
    endtask

    logic [31:0] res;

    initial begin
        Rst      = 1'b0;
        DemodEn  = 1'b0;
        AdcValid = 1'b0;
        AdcData  = '0;
        tick();
        tick();
        checkVal("rstReady", 32'(DemodReady), 32'd0);
        checkVal("rstResult", DemodResult, 32'd0);
        checkVal("rstBusy", 32'(Busy), 32'd0);
        @(negedge Clk);
        Rst = 1'b1;
        tick();

        // Directed patterns.
        doAcq(0, 0, 1'b0, 1, res);
        checkVal("constZero", res, 32'h0000_0000);
        doAcq(1, 0, 1'b0, 10, res);
        checkVal("inPhaseI", res, 32'h0640_0000);
        doAcq(2, 0, 1'b0, 1, res);
        checkVal("satPos", res, 32'h7FFF_0000);
        doAcq(3, 0, 1'b0, 1, res);
        checkVal("satNegI", 32'(res[31:16]), 32'h0000_8000);
        doAcq(1, 1, 1'b0, 2, res);
        checkVal("toggleValid", res, 32'h0640_0000);

        // Abort after five samples: Ready must never rise.
        DemodEn  = 1'b1;
        AdcValid = 1'b1;
        AdcData  = TbAdcW'(100);
        tick();
        for (int i = 0; i < 5; i++) tick();
        DemodEn = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (DemodReady) checkVal("abortReady", 32'(DemodReady), 32'd0);
        end
        checkVal("abortIdleBusy", 32'(Busy), 32'd0);
        AdcValid = 1'b0;
        doAcq(1, 0, 1'b0, 1, res);
        checkVal("afterAbort", res, 32'h0640_0000);

        // Abort in the finishing cycle, then a clean request.
        doAcq(4, 0, 1'b1, 0, res);
        doAcq(1, 2, 1'b0, 1, res);
        checkVal("afterFinishAbort", res, 32'h0640_0000);

        // Randomized requests.
        for (int r = 0; r < 10; r++) begin
            doAcq(int'($urandom_range(4)), int'($urandom_range(2)), 1'b0,
                  int'($urandom_range(4)), res);
        end

        // Asynchronous reset during acquisition.
        DemodEn  = 1'b1;
        AdcValid = 1'b1;
        AdcData  = TbAdcW'(100);
        tick();
        for (int i = 0; i < 3; i++) tick();
        #2;
        Rst = 1'b0;
        #1;
        checkVal("midRstReady", 32'(DemodReady), 32'd0);
        checkVal("midRstResult", DemodResult, 32'd0);
        checkVal("midRstBusy", 32'(Busy), 32'd0);
        @(negedge Clk);
        DemodEn  = 1'b0;
        AdcValid = 1'b0;
        Rst      = 1'b1;
        tick();
        doAcq(1, 0, 1'b0, 1, res);
        checkVal("afterRst", res, 32'h0640_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/demod_channel_responder.md
Name: demod_channel_responder

Overview:
- Single-channel digital phase-sensitive demodulator; it is the responder side of the DemodEn/DemodReady/DemodResult handshake driven by the frame-demodulation requester.
- While its enable is held high it accumulates a fixed number of ADC samples against in-phase and quadrature square-wave references.
- It then presents a packed 32-bit I/Q result with Ready, and holds both until the requester drops the enable.
- One instance is built per measurement channel (Ch1, Ch2).

Parameters:
- AdcWidth, 14: signed ADC sample width.
- NumSamples, 1024: valid samples accumulated per demodulation, range 2..65535.
- HalfPeriod, 8: samples per half reference cycle; must be even, at least 2.
- ShiftR, 8: arithmetic right shift applied to each accumulator before saturation to 16 bits.

Ports:
- Clk, input, 1: system clock.
- Rst, input, 1: asynchronous active-low reset.
- DemodEn, input, 1: request from the requester. A rising level starts an acquisition; the requester holds it high until Ready is seen.
- AdcData, input, AdcWidth: signed two's-complement ADC sample.
- AdcValid, input, 1: AdcData is valid in this cycle.
- DemodReady, output, 1: result valid; held until DemodEn goes low.
- DemodResult, output, 32: bits [31:16] are saturated I, bits [15:0] are saturated Q, both signed.
- Busy, output, 1: high in ACQ and FINISH (debug/status).

Behaviour:
- Reset (Rst=0, asynchronous): DemodReady=0, DemodResult=0, Busy=0, state=IDLE, accumulators=0, phase=0, sample count=0.
- States: IDLE, ACQ, FINISH, HOLD.
- IDLE:
  - If DemodEn=1: clear AccI, AccQ, phase and count; go to ACQ on the next edge. Samples arriving in the entry cycle are ignored.
  - Otherwise remain in IDLE.
- ACQ:
  - On each edge with AdcValid=1, AccI += sI·AdcData and AccQ += sQ·AdcData.
  - sI = +1 when phase < HalfPeriod, else −1.
  - sQ = +1 when HalfPeriod/2 ≤ phase < 3·HalfPeriod/2, else −1.
  - Phase advances modulo 2·HalfPeriod; count increments.
  - When count reaches NumSamples (on the edge that accepts the last sample), go to FINISH.
  - AdcValid=0 cycles change nothing.
- FINISH:
  - DemodResult = {sat16(AccI >>> ShiftR), sat16(AccQ >>> ShiftR)}.
  - DemodReady=1, registered on the same edge; go to HOLD.
- HOLD:
  - DemodReady and DemodResult remain constant while DemodEn=1.
  - When DemodEn=0: DemodReady=0 on the next edge and go to IDLE. DemodResult keeps its last value.
- Latency: DemodReady rises exactly 1 clock after the edge that captured the NumSamples-th valid sample.
- Abort: DemodEn=0 in ACQ or FINISH returns to IDLE on the next edge with DemodReady staying 0. The partial accumulation is discarded.
- Re-trigger: a new acquisition only starts from IDLE. DemodEn must be seen low at least one cycle after Ready before the next request.
- Arithmetic:
  - Accumulators are signed, AdcWidth+16 bits wide; they cannot overflow for NumSamples ≤ 65535.
  - Negation of the most-negative sample is done at accumulator width, so no wrap occurs.
  - sat16 clamps to the range 0x8000..0x7FFF.
- Reset mid-operation forces IDLE immediately; no partial result is ever presented.

Decomposition:
- Shared package:
  - State encoding constants.
  - Result packing field positions: I_MSB=31, I_LSB=16, Q_MSB=15, Q_LSB=0.
  - sat16 function.
- Sub-module demod_ref_gen (natural):
  - Holds the phase counter and sI/sQ sign outputs.
  - Has clear and advance inputs; parameterised by HalfPeriod.

Test Plan:
1. NumSamples=16, HalfPeriod=4, ShiftR=0; AdcData=+100 constant, AdcValid always 1 -> DemodReady 1 clock after the 16th sample; DemodResult=0x00000000.
2. Same parameters; AdcData=+100 for phases 0–3 and −100 for phases 4–7, in phase with the reference -> I=1600 (0x0640), Q=0; DemodResult=0x06400000.
3. NumSamples=1024, ShiftR=0; AdcData=+8191 in phase with sI -> I saturates to 0x7FFF; Q=0x0000.
4. AdcValid toggling 1-0-1-0 through scenario 2 -> identical result; Ready is delayed by the number of invalid cycles.
5. DemodEn held high 10 cycles after Ready -> Ready=1 and Result stable for all 10 cycles; DemodEn low -> Ready=0 on the next edge, Result unchanged.
6. DemodEn dropped after 5 samples -> Ready never asserts. Then re-request with scenario 2 stimulus -> fresh result 0x06400000. Rst pulsed mid-ACQ -> all outputs 0 immediately.
